// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Byte-offset bits below the word index in a byte address
    localparam int unsigned BYTE_OFF_W = 2;

    // Largest wait-state count the 4-bit wait counter can express
    localparam int unsigned MAX_WAIT_CYCLES = 15;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage with a synchronous write port and a registered read port.
// Only the read register is reset; the storage itself keeps its contents across reset.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Word write on the clock edge; no reset so contents survive a core reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Registered read; holds its last value whenever no read is requested
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS core: answers load/store requests after
// WAIT_CYCLES wait states (0..15) and stalls the core until mem_ready.
// Optional misaligned-access detection is enabled by defining DMEM_ALIGN_CHECK_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no access in flight; a request here is accepted and latched
// ST_WAIT | counting wait states down in wcnt; dropping the request aborts
// ST_RESP | one-cycle completion: mem_ready=1, read_mem/align_err valid
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr_mem,
    input  logic [31:0] write_mem,
    output logic [31:0] read_mem,
    output logic        mem_ready,
    output logic        stall,
    output logic        align_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WCNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_e   state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          mis_q, mis_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          req;
    logic          mis_now;
    logic          enter_resp;
    logic          acc_rd, acc_wr, acc_mis;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic          arr_we, arr_re;
    logic [31:0]   arr_rdata;

    assign req = mem_read | mem_write;

`ifdef DMEM_ALIGN_CHECK_EN
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_mem[31:AW+BYTE_OFF_W];
    assign mis_now          = |addr_mem[BYTE_OFF_W-1:0];
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_mem[31:AW+BYTE_OFF_W], addr_mem[BYTE_OFF_W-1:0]};
    assign mis_now          = 1'b0;
`endif

    // Next-state logic: accept, count wait states down, abort or respond
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        mis_d      = mis_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    rd_d    = mem_read;
                    wr_d    = mem_write;
                    mis_d   = mis_now;
                    idx_d   = addr_mem[AW+BYTE_OFF_W-1:BYTE_OFF_W];
                    wdata_d = write_mem;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WCNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                    wcnt_d  = 4'd0;
                end else if (wcnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = 4'd0;
            end
        endcase
    end

    // With zero wait states RESP is entered straight from IDLE, so the live inputs are used
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_rd    = mem_read;
            acc_wr    = mem_write;
            acc_mis   = mis_now;
            acc_idx   = addr_mem[AW+BYTE_OFF_W-1:BYTE_OFF_W];
            acc_wdata = write_mem;
        end else begin
            acc_rd    = rd_q;
            acc_wr    = wr_q;
            acc_mis   = mis_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
        end
    end

    // Store wins over load; a misaligned access touches nothing
    assign arr_we = enter_resp & acc_wr & ~acc_mis;
    assign arr_re = enter_resp & acc_rd & ~acc_wr & ~acc_mis;

    // FSM, wait counter and latched request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            mis_q   <= mis_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst     (reset),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (acc_idx),
        .wdata_i (acc_wdata),
        .rdata_o (arr_rdata)
    );

`ifdef DMEM_ALIGN_CHECK_EN
    logic align_err_q, align_err_d;

    assign align_err_d = enter_resp & acc_mis;

    // Misalignment flag, set only for the RESP cycle of the offending access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end

    assign align_err = align_err_q;
    assign read_mem  = align_err_q ? 32'd0 : arr_rdata;
`else
    assign align_err = 1'b0;
    assign read_mem  = arr_rdata;
`endif

    assign mem_ready = (state_q == ST_RESP);
    assign stall     = ~reset & req & ~mem_ready;

endmodule
